// File: rtl/param_dual_port_memory.sv
// rtl/param_dual_port_memory.sv - parametrised true dual-port synchronous RAM
//
// Purpose: two independent read/write ports on one word array, with
// registered read data, per-read valid pulses, an optional extra output
// register, selectable cross-port read-during-write behaviour and
// same-address write collision detection.
//
// Optional feature macro: PARAM_DPM_MEM_CLEAR_EN
//   defined   - after reset a sequencer writes zero to every word, one per
//               cycle; busy is high and port requests are ignored meanwhile.
//   undefined - no sequencer, busy tied low, contents not initialised.
//
// Ports:
//   clk                  single clock, rising edge
//   reset_n              synchronous active-low reset
//   en_a / en_b          port request strobe
//   we_a / we_b          1 = write, 0 = read (qualified by en)
//   addr_a / addr_b      word address
//   data_a / data_b      write data
//   q_a / q_b            read data (holds between reads)
//   valid_a / valid_b    one-cycle pulse per completed read
//   collision            one-cycle pulse after both ports wrote one address
//   busy                 clear sequencer active
module param_dual_port_memory #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 10,
    parameter int OUT_REG    = 0,
    parameter int READ_MODE  = 0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  en_a,
    input  logic                  we_a,
    input  logic [ADDR_WIDTH-1:0] addr_a,
    input  logic [DATA_WIDTH-1:0] data_a,
    output logic [DATA_WIDTH-1:0] q_a,
    output logic                  valid_a,
    input  logic                  en_b,
    input  logic                  we_b,
    input  logic [ADDR_WIDTH-1:0] addr_b,
    input  logic [DATA_WIDTH-1:0] data_b,
    output logic [DATA_WIDTH-1:0] q_b,
    output logic                  valid_b,
    output logic                  collision,
    output logic                  busy
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Port-indexed views so both ports share one generate body (0 = A, 1 = B).
    logic [ADDR_WIDTH-1:0] addr [2];
    logic [DATA_WIDTH-1:0] wdata [2];
    logic [DATA_WIDTH-1:0] q_out [2];
    logic                  valid_out [2];
    logic                  rd [2];
    logic                  wr [2];
    logic                  busy_int;

    assign addr[0]  = addr_a;
    assign addr[1]  = addr_b;
    assign wdata[0] = data_a;
    assign wdata[1] = data_b;
    assign q_a      = q_out[0];
    assign q_b      = q_out[1];
    assign valid_a  = valid_out[0];
    assign valid_b  = valid_out[1];
    assign busy     = busy_int;

    // Requests are dropped while the clear sweep owns the array.
    assign rd[0] = en_a & ~we_a & ~busy_int;
    assign rd[1] = en_b & ~we_b & ~busy_int;
    assign wr[0] = en_a &  we_a & ~busy_int;
    assign wr[1] = en_b &  we_b & ~busy_int;

`ifdef PARAM_DPM_MEM_CLEAR_EN
    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_CLEAR = 1'b1;

    logic [0:0]            state;
    logic [ADDR_WIDTH-1:0] clr_addr;

    // Reset parks the sequencer at the start of the sweep, so a reset in the
    // middle of a clear restarts from address 0.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state    <= ST_CLEAR;
            clr_addr <= '0;
        end else if (state == ST_CLEAR) begin
            clr_addr <= clr_addr + 1'b1;
            if (clr_addr == '1) begin
                state <= ST_IDLE;
            end
        end
    end

    assign busy_int = (state == ST_CLEAR);
`else
    assign busy_int = 1'b0;
`endif

    // Port B is applied first so that port A wins a same-address write.
    always_ff @(posedge clk) begin
        if (reset_n) begin
`ifdef PARAM_DPM_MEM_CLEAR_EN
            if (state == ST_CLEAR) begin
                mem[clr_addr] <= '0;
            end
`endif
            if (wr[1]) begin
                mem[addr[1]] <= wdata[1];
            end
            if (wr[0]) begin
                mem[addr[0]] <= wdata[0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            collision <= 1'b0;
        end else begin
            collision <= wr[0] & wr[1] & (addr[0] == addr[1]);
        end
    end

    for (genvar p = 0; p < 2; p++) begin : g_port
        logic [DATA_WIDTH-1:0] rd_word;
        logic [DATA_WIDTH-1:0] s1_data;
        logic [DATA_WIDTH-1:0] s2_data;
        logic [DATA_WIDTH-1:0] last_data;
        logic                  s1_valid;
        logic                  s2_valid;
        logic                  last_valid;
        logic [DATA_WIDTH-1:0] q_r;
        logic                  valid_r;

        // The array read samples the pre-write contents; bypass mode
        // forwards the other port's write data for a matching address.
        assign rd_word = (READ_MODE != 0 && wr[1-p] && addr[1-p] == addr[p])
                         ? wdata[1-p] : mem[addr[p]];

        assign last_data  = (OUT_REG != 0) ? s2_data  : s1_data;
        assign last_valid = (OUT_REG != 0) ? s2_valid : s1_valid;

        always_ff @(posedge clk) begin
            if (!reset_n) begin
                s1_valid <= 1'b0;
                s2_valid <= 1'b0;
                valid_r  <= 1'b0;
                q_r      <= '0;
            end else begin
                s1_valid <= rd[p];
                if (rd[p]) begin
                    s1_data <= rd_word;
                end
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    s2_data <= s1_data;
                end
                valid_r <= last_valid;
                if (last_valid) begin
                    q_r <= last_data;
                end
            end
        end

        assign q_out[p]     = q_r;
        assign valid_out[p] = valid_r;
    end

endmodule

// File: tb/tb_param_dual_port_memory.sv
// tb/tb_param_dual_port_memory.sv - directed bench for param_dual_port_memory
module tb_param_dual_port_memory;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        en_a, we_a, en_b, we_b;
    logic [9:0]  addr_a, addr_b;
    logic [15:0] data_a, data_b;

    logic [15:0] q0_a, q0_b, q1_a, q1_b;
    logic        v0_a, v0_b, v1_a, v1_b, coll0, coll1, busy0, busy1;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    // d0: defaults (OUT_REG=0, READ_MODE=0)
    param_dual_port_memory #(.DATA_WIDTH(16), .ADDR_WIDTH(10), .OUT_REG(0), .READ_MODE(0)) d0 (
        .clk(clk), .reset_n(reset_n),
        .en_a(en_a), .we_a(we_a), .addr_a(addr_a), .data_a(data_a), .q_a(q0_a), .valid_a(v0_a),
        .en_b(en_b), .we_b(we_b), .addr_b(addr_b), .data_b(data_b), .q_b(q0_b), .valid_b(v0_b),
        .collision(coll0), .busy(busy0));

    // d1: output register and bypass read mode
    param_dual_port_memory #(.DATA_WIDTH(16), .ADDR_WIDTH(10), .OUT_REG(1), .READ_MODE(1)) d1 (
        .clk(clk), .reset_n(reset_n),
        .en_a(en_a), .we_a(we_a), .addr_a(addr_a), .data_a(data_a), .q_a(q1_a), .valid_a(v1_a),
        .en_b(en_b), .we_b(we_b), .addr_b(addr_b), .data_b(data_b), .q_b(q1_b), .valid_b(v1_b),
        .collision(coll1), .busy(busy1));

`ifdef PARAM_DPM_MEM_CLEAR_EN
    logic [15:0] q2_a, q2_b;
    logic        v2_a, v2_b, coll2, busy2;

    param_dual_port_memory #(.DATA_WIDTH(16), .ADDR_WIDTH(4), .OUT_REG(0), .READ_MODE(0)) d2 (
        .clk(clk), .reset_n(reset_n),
        .en_a(en_a), .we_a(we_a), .addr_a(addr_a[3:0]), .data_a(data_a), .q_a(q2_a), .valid_a(v2_a),
        .en_b(en_b), .we_b(we_b), .addr_b(addr_b[3:0]), .data_b(data_b), .q_b(q2_b), .valid_b(v2_b),
        .collision(coll2), .busy(busy2));
`endif

    typedef struct {
        logic        en_a, we_a;
        logic [9:0]  addr_a;
        logic [15:0] data_a;
        logic        en_b, we_b;
        logic [9:0]  addr_b;
        logic [15:0] data_b;
        logic [15:0] eq_a;
        logic        ev_a;
        logic [15:0] eq_b;
        logic        ev_b;
        logic        ecoll;
    } vec_t;

    vec_t vt [13];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one request cycle at the falling edge; return 1 ns after the
    // rising edge that samples it.
    task automatic cyc(input logic ea, input logic wa, input logic [9:0] aa, input logic [15:0] da,
                       input logic eb, input logic wb, input logic [9:0] ab, input logic [15:0] db);
        @(negedge clk);
        en_a = ea; we_a = wa; addr_a = aa; data_a = da;
        en_b = eb; we_b = wb; addr_b = ab; data_b = db;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cyc(0, 0, 10'h0, 16'h0, 0, 0, 10'h0, 16'h0);
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while ((busy0 || busy1) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("busy_wait_bound", 16'(busy0 | busy1), 16'h0);
    endtask

    logic [15:0] exp_after_reset;

    initial begin
        reset_n = 1'b0;
        en_a = 0; we_a = 0; addr_a = '0; data_a = '0;
        en_b = 0; we_b = 0; addr_b = '0; data_b = '0;

        //          ea we addr     data      eb we addr     data      q_a      va q_b      vb coll
        vt[0]  = '{1, 1, 10'h001, 16'h0001, 0, 0, 10'h000, 16'h0000, 16'h0000, 0, 16'h0000, 0, 0};
        vt[1]  = '{1, 0, 10'h001, 16'h0000, 1, 1, 10'h010, 16'h00AA, 16'h0000, 0, 16'h0000, 0, 0};
        vt[2]  = '{1, 1, 10'h010, 16'h0055, 1, 0, 10'h010, 16'h0000, 16'h0001, 1, 16'h0000, 0, 0};
        vt[3]  = '{1, 1, 10'h3FF, 16'h1111, 1, 1, 10'h3FF, 16'h2222, 16'h0001, 0, 16'h00AA, 1, 1};
        vt[4]  = '{0, 0, 10'h000, 16'h0000, 0, 0, 10'h000, 16'h0000, 16'h0001, 0, 16'h00AA, 0, 0};
        vt[5]  = '{1, 0, 10'h3FF, 16'h0000, 1, 0, 10'h3FF, 16'h0000, 16'h0001, 0, 16'h00AA, 0, 0};
        vt[6]  = '{1, 0, 10'h010, 16'h0000, 1, 0, 10'h001, 16'h0000, 16'h1111, 1, 16'h1111, 1, 0};
        vt[7]  = '{1, 1, 10'h020, 16'hBEEF, 1, 1, 10'h021, 16'hCAFE, 16'h0055, 1, 16'h0001, 1, 0};
        vt[8]  = '{1, 0, 10'h021, 16'h0000, 1, 0, 10'h020, 16'h0000, 16'h0055, 0, 16'h0001, 0, 0};
        vt[9]  = '{0, 0, 10'h000, 16'h0000, 0, 0, 10'h000, 16'h0000, 16'hCAFE, 1, 16'hBEEF, 1, 0};
        vt[10] = '{1, 1, 10'h000, 16'h1234, 1, 1, 10'h000, 16'h5678, 16'hCAFE, 0, 16'hBEEF, 0, 1};
        vt[11] = '{0, 0, 10'h000, 16'h0000, 1, 0, 10'h000, 16'h0000, 16'hCAFE, 0, 16'hBEEF, 0, 0};
        vt[12] = '{0, 0, 10'h000, 16'h0000, 0, 0, 10'h000, 16'h0000, 16'hCAFE, 0, 16'h1234, 1, 0};

        repeat (2) @(posedge clk);
        #1;
        chk("rst_q_a", q0_a, 16'h0);
        chk("rst_q_b", q0_b, 16'h0);
        chk("rst_valid", 16'({v0_a, v0_b, v1_a, v1_b}), 16'h0);
        chk("rst_collision", 16'(coll0), 16'h0);
        @(negedge clk);
        reset_n = 1'b1;
        wait_ready();

        for (int i = 0; i < 13; i++) begin
            cyc(vt[i].en_a, vt[i].we_a, vt[i].addr_a, vt[i].data_a,
                vt[i].en_b, vt[i].we_b, vt[i].addr_b, vt[i].data_b);
            chk($sformatf("vec%0d_q_a", i), q0_a, vt[i].eq_a);
            chk($sformatf("vec%0d_valid_a", i), 16'(v0_a), 16'(vt[i].ev_a));
            chk($sformatf("vec%0d_q_b", i), q0_b, vt[i].eq_b);
            chk($sformatf("vec%0d_valid_b", i), 16'(v0_b), 16'(vt[i].ev_b));
            chk($sformatf("vec%0d_collision", i), 16'(coll0), 16'(vt[i].ecoll));
        end

        // Output-register pipeline: back-to-back reads on port B
        cyc(0, 0, 10'h0, 16'h0, 1, 1, 10'h004, 16'h0002);
        cyc(0, 0, 10'h0, 16'h0, 1, 1, 10'h005, 16'h0003);
        cyc(0, 0, 10'h0, 16'h0, 1, 1, 10'h006, 16'h0004);
        cyc(0, 0, 10'h0, 16'h0, 1, 0, 10'h004, 16'h0000);
        chk("oreg_r0_valid", 16'(v1_b), 16'h0);
        cyc(0, 0, 10'h0, 16'h0, 1, 0, 10'h005, 16'h0000);
        chk("oreg_r1_valid", 16'(v1_b), 16'h0);
        chk("noreg_q_b", q0_b, 16'h0002);
        chk("noreg_valid_b", 16'(v0_b), 16'h1);
        cyc(0, 0, 10'h0, 16'h0, 1, 0, 10'h006, 16'h0000);
        chk("oreg_q0", q1_b, 16'h0002);
        chk("oreg_v0", 16'(v1_b), 16'h1);
        idle();
        chk("oreg_q1", q1_b, 16'h0003);
        chk("oreg_v1", 16'(v1_b), 16'h1);
        idle();
        chk("oreg_q2", q1_b, 16'h0004);
        chk("oreg_v2", 16'(v1_b), 16'h1);
        idle();
        chk("oreg_hold_q", q1_b, 16'h0004);
        chk("oreg_idle_v", 16'(v1_b), 16'h0);

        // Cross-port read-during-write
        cyc(0, 0, 10'h0, 16'h0, 1, 1, 10'h010, 16'h00AA);
        cyc(1, 1, 10'h010, 16'h0055, 1, 0, 10'h010, 16'h0000);
        idle();
        chk("rdw_old_q_b", q0_b, 16'h00AA);
        chk("rdw_old_v_b", 16'(v0_b), 16'h1);
        idle();
        chk("rdw_new_q_b", q1_b, 16'h0055);
        chk("rdw_new_v_b", 16'(v1_b), 16'h1);

        // Reset while a read is in flight
        cyc(1, 0, 10'h001, 16'h0, 0, 0, 10'h0, 16'h0);
        @(negedge clk);
        reset_n = 1'b0;
        en_a = 0; en_b = 0;
        @(posedge clk);
        #1;
        chk("rst_flight_v0", 16'(v0_a), 16'h0);
        chk("rst_flight_q0", q0_a, 16'h0);
        chk("rst_flight_q1", q1_a, 16'h0);
        @(posedge clk);
        #1;
        chk("rst_flight_v1", 16'(v1_a), 16'h0);
        @(negedge clk);
        reset_n = 1'b1;
        wait_ready();
        cyc(1, 0, 10'h001, 16'h0, 0, 0, 10'h0, 16'h0);
        idle();
`ifdef PARAM_DPM_MEM_CLEAR_EN
        exp_after_reset = 16'h0000;
`else
        exp_after_reset = 16'h0001;
`endif
        chk("post_rst_q", q0_a, exp_after_reset);
        chk("post_rst_v", 16'(v0_a), 16'h1);

`ifdef PARAM_DPM_MEM_CLEAR_EN
        begin
            int cnt;
            for (int i = 0; i < 16; i++) begin
                cyc(1, 1, 10'(i), 16'hFFFF, 0, 0, 10'h0, 16'h0);
            end
            @(negedge clk);
            reset_n = 1'b0;
            en_a = 0;
            repeat (2) @(posedge clk);
            @(negedge clk);
            reset_n = 1'b1;
            cnt = 0;
            while (busy2 && cnt < 100) begin
                cnt++;
                @(posedge clk);
                @(negedge clk);
            end
            chk("clear_busy_cycles", 16'(cnt), 16'd16);
            for (int i = 0; i < 16; i++) begin
                cyc(1, 0, 10'(i), 16'h0, 0, 0, 10'h0, 16'h0);
                if (i > 0) begin
                    chk($sformatf("clear_q_%0d", i - 1), q2_a, 16'h0000);
                    chk($sformatf("clear_v_%0d", i - 1), 16'(v2_a), 16'h1);
                end
            end
            idle();
            chk("clear_q_15", q2_a, 16'h0000);
            chk("clear_v_15", 16'(v2_a), 16'h1);
        end
`else
        chk("busy_tied_low", 16'(busy0 | busy1), 16'h0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/param_dual_port_memory.md
Name: param_dual_port_memory

Overview:
- Parametrised true dual-port synchronous RAM; successor to the fixed 16-bit x 1024 dual-port memory used by the datapath and the memory-mapped I/O path.
- Adds width/depth parameters, per-port enables with read-valid tracking, an optional output register stage, selectable cross-port read-during-write semantics and write-collision detection.
- Sits between the CPU load/store unit (port A) and the instruction/peripheral side (port B).

Parameters:
- DATA_WIDTH, 16, word width in bits.
- ADDR_WIDTH, 10, address width; depth = 2**ADDR_WIDTH words.
- OUT_REG, 0, 0 = read data one cycle after request; 1 = extra output register, read data two cycles after request.
- READ_MODE, 0, cross-port read of an address written the same cycle: 0 = old data, 1 = new data (bypass).

Ports:
- clk  in  1  single clock; all logic on rising edge.
- reset_n  in  1  synchronous, active-low reset.
- en_a  in  1  port A request strobe.
- we_a  in  1  port A write (1) / read (0); qualified by en_a.
- addr_a  in  ADDR_WIDTH  port A word address.
- data_a  in  DATA_WIDTH  port A write data.
- q_a  out  DATA_WIDTH  port A read data.
- valid_a  out  1  q_a holds data for a completed read, one-cycle pulse per read.
- en_b, we_b, addr_b, data_b, q_b, valid_b: same as port A, for port B.
- collision  out  1  one-cycle pulse: both ports wrote the same address.
- busy  out  1  clear sequencer active; requests ignored.

Behaviour:
- Reset (reset_n=0 at edge): q_a, q_b = 0; valid_a, valid_b, collision = 0; pipeline valids flushed; in-flight reads discarded. Writes presented in a reset cycle are suppressed. Memory contents are preserved (except under MEM_CLEAR_EN).
- Write: en=1, we=1 at edge N; memory updated at edge N. No valid pulse. q holds its previous value.
- Read: en=1, we=0 at edge N.
  - OUT_REG=0: q and valid are updated at edge N+1.
  - OUT_REG=1: q and valid are updated at edge N+2.
  - Back-to-back reads are fully pipelined, one per cycle per port.
- Idle (en=0): q holds, valid=0.
- Cross-port read-during-write: port X reads address K while port Y writes K in the same cycle.
  - READ_MODE=0: X returns the pre-write value.
  - READ_MODE=1: X returns Y's data_y.
- Both ports write the same address in the same cycle: port A's data is stored.
  - collision=1 for exactly the following cycle, then 0.
  - Different addresses never assert collision.
- Both ports read the same address: both return the same word at the same latency.
- Address wrap: addresses are exactly ADDR_WIDTH bits; no out-of-range case exists. Address 2**ADDR_WIDTH-1 is valid.
- Output pipeline (OUT_REG=1): stage-1 and stage-2 valid bits shift every cycle. No stall input exists.

Optional Feature:
- Macro: PARAM_DPM_MEM_CLEAR_EN.
- Defined: after reset_n deasserts, an FSM runs IDLE -> CLEAR -> IDLE.
  - CLEAR writes 0 to addresses 0..2**ADDR_WIDTH-1, one per cycle.
  - busy=1 throughout CLEAR; en_a and en_b are ignored; valid_a and valid_b stay 0.
  - busy falls on the cycle after the last address is written.
  - Reset asserted mid-clear restarts the sweep at address 0.
- Undefined: no FSM; busy is tied 0; memory is not initialised.

Test Plan:
- Defaults: A writes 0x0001 @0x001; next cycle A reads 0x001 -> q_a=0x0001, valid_a=1 exactly one cycle after the read request.
- OUT_REG=1: B issues reads @0x004, 0x005 and 0x006 back-to-back after writing 0x0002, 0x0003, 0x0004 -> q_b=0x0002, 0x0003, 0x0004 on consecutive cycles, first one two cycles after the first request.
- READ_MODE=0 vs 1: @0x010 holds 0x00AA; A writes 0x0055 @0x010 while B reads 0x010 -> q_b=0x00AA (mode 0) / 0x0055 (mode 1).
- Same-cycle writes @0x3FF: A=0x1111, B=0x2222 -> collision pulses 1 cycle; later read @0x3FF returns 0x1111.
- Reset mid-read: issue a read, assert reset_n=0 the next cycle -> valid stays 0, q=0; memory word still readable after release.
- PARAM_DPM_MEM_CLEAR_EN, ADDR_WIDTH=4: preload 0xFFFF, reset -> busy high 16 cycles; reads of 0x0..0xF then return 0x0000.
